// File: rtl/diff_scan_ctrl.sv
// Multi-cycle "diff" sequencer: index of the lowest bit where a and b differ, scanning a^b STEP bits per cycle.
// Optional macro DIFF_CHAIN_EN lets a new operation be accepted on the result-handshake edge.
module diff_scan_ctrl #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res,
    output logic             eq,
    output logic             busy
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] x_r, x_s;
    logic [IW-1:0]    idx_r, idx_s;
    logic [31:0]      res_r, res_s;
    logic             eq_r, eq_s;
    logic             res_valid_r, res_valid_s;
    logic             busy_r;
    logic             load_s;
    logic [WIDTH-1:0] diff_s;
    logic [STEP-1:0]  chunk_s;

    function automatic logic [PW-1:0] low_pos(input logic [STEP-1:0] c);
        logic [PW-1:0] p;
        p = {PW{1'b0}};
        for (int k = STEP - 1; k >= 0; k--) begin
            if (c[k]) begin
                p = PW'(k);
            end
        end
        return p;
    endfunction

`ifdef DIFF_CHAIN_EN
    assign start_ready = (state_r == IDLE) || ((state_r == DONE) && res_ready);
`else
    assign start_ready = (state_r == IDLE);
`endif

    assign res_valid = res_valid_r;
    assign res       = res_r;
    assign eq        = eq_r;
    assign busy      = busy_r;
    assign diff_s    = a ^ b;
    assign chunk_s   = x_r[STEP-1:0];

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        idx_s       = idx_r;
        res_s       = res_r;
        eq_s        = eq_r;
        res_valid_s = res_valid_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                load_s = start_valid;
            end
            SCAN: begin
                // Equal operands also spend one SCAN cycle so their result latency is one edge.
                if (x_r == {WIDTH{1'b0}}) begin
                    res_s       = 32'd0;
                    res_valid_s = 1'b1;
                    state_s     = DONE;
                end else if (chunk_s != {STEP{1'b0}}) begin
                    res_s       = 32'(idx_r + IW'(low_pos(chunk_s)));
                    res_valid_s = 1'b1;
                    state_s     = DONE;
                end else begin
                    x_s   = x_r >> STEP;
                    idx_s = idx_r + IW'(STEP);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s     = IDLE;
                    res_valid_s = 1'b0;
`ifdef DIFF_CHAIN_EN
                    load_s      = start_valid;
`endif
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s     = IDLE;
                res_valid_s = 1'b0;
            end
        endcase
        if (load_s) begin
            x_s     = diff_s;
            idx_s   = {IW{1'b0}};
            eq_s    = (diff_s == {WIDTH{1'b0}});
            state_s = SCAN;
        end else begin
            x_s = x_s;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            x_r         <= {WIDTH{1'b0}};
            idx_r       <= {IW{1'b0}};
            res_r       <= 32'd0;
            eq_r        <= 1'b0;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            x_r         <= x_s;
            idx_r       <= idx_s;
            res_r       <= res_s;
            eq_r        <= eq_s;
            res_valid_r <= res_valid_s;
            busy_r      <= (state_s != IDLE);
        end
    end
endmodule

// File: tb/tb_diff_scan_ctrl.sv
// Randomized self-checking bench for diff_scan_ctrl against a bit-loop reference model.
module tb_diff_scan_ctrl;
    localparam int WIDTH = 32;
    localparam int STEP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res;
    logic        eq;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    diff_scan_ctrl #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
        .res(res), .eq(eq), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_idx(input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] d;
        int r;
        d = av ^ bv;
        r = 0;
        for (int i = 31; i >= 0; i--) if (d[i]) r = i;
        return r;
    endfunction

    function automatic int ref_lat(input logic [31:0] av, input logic [31:0] bv);
        if (av == bv) return 1;
        return ref_idx(av, bv) / STEP + 1;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("start_ready_wait", {31'd0, start_ready}, 32'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", {31'd0, res_valid}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int stall);
        int acc;
        logic [31:0] er;
        logic        ee;
        er = 32'(ref_idx(av, bv));
        ee = (av == bv);
        @(negedge clk);
        a = av; b = bv; start_valid = 1'b1; res_ready = 1'b0;
        wait_ready();
        acc = cyc + 1;
        @(negedge clk);
        start_valid = 1'b0;
        a = $urandom; b = $urandom;
        chk("busy_in_op", {31'd0, busy}, 32'd1);
        chk("no_early_valid", {31'd0, res_valid}, 32'd0);
        wait_valid();
        chk("latency", 32'(cyc - acc), 32'(ref_lat(av, bv)));
        chk("res", res, er);
        chk("eq", {31'd0, eq}, {31'd0, ee});
        chk("ready_in_done", {31'd0, start_ready}, 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, res_valid}, 32'd1);
            chk("stall_res", res, er);
            chk("stall_eq", {31'd0, eq}, {31'd0, ee});
            chk("stall_ready", {31'd0, start_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_valid", {31'd0, res_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, start_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2, hs1, gap;
        logic [31:0] ra, mask;
        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_res", res, 32'd0);
        chk("rst_eq", {31'd0, eq}, 32'd0);
        rst = 1'b0;

        run_op(32'h0000_0000, 32'h0000_0001, 0);
        run_op(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1);
        run_op(32'h1234_5678, 32'h1234_5678, 0);
        run_op(32'h0000_0000, 32'h0001_0100, 5);

        // Asynchronous reset in the middle of a long scan.
        @(negedge clk);
        a = 32'h0; b = 32'h8000_0000; start_valid = 1'b1;
        wait_ready();
        @(negedge clk);
        start_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("scan_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, start_ready}, 32'd1);
        chk("arst_res", res, 32'd0);
        chk("arst_eq", {31'd0, eq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32'h0000_0000, 32'h0000_0040, 0);

        for (int t = 0; t < 24; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0: mask = 32'd0;
                1: mask = 32'd1 << $urandom_range(0, 31);
                default: mask = $urandom;
            endcase
            run_op(ra, ra ^ mask, $urandom_range(0, 3));
        end

        // Back-to-back operations with start_valid held.
        @(negedge clk);
        a = 32'h0; b = 32'h0000_0100; start_valid = 1'b1; res_ready = 1'b1;
        wait_ready();
        acc1 = cyc + 1;
        @(negedge clk);
        a = 32'h5; b = 32'h4;
        wait_valid();
        chk("b2b_res1", res, 32'd8);
        chk("b2b_lat1", 32'(cyc - acc1), 32'd3);
        hs1 = cyc + 1;
        wait_ready();
        acc2 = cyc + 1;
`ifdef DIFF_CHAIN_EN
        gap = 0;
`else
        gap = 1;
`endif
        chk("b2b_accept", 32'(acc2 - hs1), 32'(gap));
        @(negedge clk);
        start_valid = 1'b0;
        wait_valid();
        chk("b2b_res2", res, 32'd0);
        chk("b2b_eq2", {31'd0, eq}, 32'd0);
        chk("b2b_lat2", 32'(cyc - acc2), 32'd1);
        @(negedge clk);
        res_ready = 1'b0;
        chk("b2b_idle", {31'd0, res_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
